clk_enable_gen: RTL

Multi-channel fractional clock-enable generator for the video/SerDes clock tree. From one fast global clock it produces `CHANNELS` single-cycle enable strobes, each at a rational rate INC/MOD of the clock (e.g. 28/30, Atari pixel rate from the pixel clock). It replaces fixed PLL dividers where rates must be re-programmed at runtime. Rate changes are glitch-free. Output is gated by a qualified PLL-lock input. Channels can be phase-aligned on demand.

---
 rtl/clk_enable_pkg.sv | 19 +
 rtl/clk_enable_nco.sv | 95 +++++++++
 rtl/clk_enable_gen.sv | 118 +++++++++++
 3 files changed

// File: rtl/clk_enable_pkg.sv
// Shared types and defaults for the fractional clock-enable generator.
package clk_enable_pkg;

    localparam int DEF_ACC_W       = 16;
    localparam int DEF_LOCK_CYCLES = 256;

    // One channel rate setting: strobe rate is inc/mod of the clock.
    typedef struct packed {
        logic [DEF_ACC_W-1:0] inc;
        logic [DEF_ACC_W-1:0] mod;
    } cfg_t;

    // Lock qualifier states.
    typedef enum logic {
        LOCK_UNLOCKED = 1'b0,
        LOCK_RUN      = 1'b1
    } lock_state_t;

endpackage

// File: rtl/clk_enable_nco.sv
// One fractional-rate channel: phase accumulator, active and pending rate,
// wrap detection and registered enable strobe.
module clk_enable_nco
    import clk_enable_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             advance,
    input  logic             disabled,
    input  logic             sync,
    input  logic             load,
    input  logic [ACC_W-1:0] load_inc,
    input  logic [ACC_W-1:0] load_mod,
    output logic             en,
    output logic             pending
);

    logic [ACC_W-1:0] acc, acc_nxt, acc_base;
    logic [ACC_W-1:0] inc, inc_nxt, mod, mod_nxt;
    logic [ACC_W-1:0] pinc, pinc_nxt, pmod, pmod_nxt;
    logic             pend, pend_nxt;
    logic             en_q, en_nxt;
    logic [ACC_W:0]   sum;
    logic             wrap, sync_hit;

    // Keep the preserved phase inside the new modulus.
    function automatic logic [ACC_W-1:0] clamp_acc(input logic [ACC_W-1:0] a,
                                                   input logic [ACC_W-1:0] m);
        return (a >= m) ? (m - ACC_W'(1)) : a;
    endfunction

    // Accumulator step, wrap detection and config application.
    always_comb begin
        sum      = {1'b0, acc} + {1'b0, inc};
        wrap     = advance && (sum >= {1'b0, mod});
        sync_hit = advance && sync;
        if (!advance || sync_hit) begin
            acc_base = '0;
        end else if (wrap) begin
            acc_base = ACC_W'(sum - {1'b0, mod});
        end else begin
            acc_base = sum[ACC_W-1:0];
        end
        en_nxt   = wrap && !sync_hit;
        acc_nxt  = acc_base;
        inc_nxt  = inc;
        mod_nxt  = mod;
        pend_nxt = pend;
        pinc_nxt = pinc;
        pmod_nxt = pmod;
        if (load && (!advance || sync_hit || wrap)) begin
            // Idle channel or a phase boundary this cycle: no glitch possible.
            inc_nxt = load_inc;
            mod_nxt = load_mod;
            acc_nxt = clamp_acc(acc_base, load_mod);
        end else if (load) begin
            pend_nxt = 1'b1;
            pinc_nxt = load_inc;
            pmod_nxt = load_mod;
        end else if (pend && (sync_hit || wrap || disabled)) begin
            // A user-disabled channel would never wrap, so release its pending rate.
            inc_nxt  = pinc;
            mod_nxt  = pmod;
            acc_nxt  = clamp_acc(acc_base, pmod);
            pend_nxt = 1'b0;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc  <= '0;
            inc  <= '0;
            mod  <= ACC_W'(1);
            pend <= 1'b0;
            pinc <= '0;
            pmod <= ACC_W'(1);
            en_q <= 1'b0;
        end else begin
            acc  <= acc_nxt;
            inc  <= inc_nxt;
            mod  <= mod_nxt;
            pend <= pend_nxt;
            pinc <= pinc_nxt;
            pmod <= pmod_nxt;
            en_q <= en_nxt;
        end
    end

    assign en      = en_q;
    assign pending = pend;

endmodule

// File: rtl/clk_enable_gen.sv
// Multi-channel fractional clock-enable generator with PLL lock qualification,
// runtime rate configuration and on-demand phase alignment.
module clk_enable_gen
    import clk_enable_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int ACC_W       = DEF_ACC_W,
    parameter int LOCK_CYCLES = DEF_LOCK_CYCLES,
    localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                PllLocked,
    input  logic [CHANNELS-1:0] ChanEnable,
    input  logic                Sync,
    input  logic                CfgValid,
    output logic                CfgReady,
    input  logic [CH_W-1:0]     CfgChan,
    input  logic [ACC_W-1:0]    CfgInc,
    input  logic [ACC_W-1:0]    CfgMod,
    output logic                CfgErr,
    output logic [CHANNELS-1:0] ClkEn,
    output logic                Running,
    output logic [CHANNELS-1:0] CfgPending
);

    localparam int CNT_W = $clog2(LOCK_CYCLES + 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_FULL = CNT_W'(LOCK_CYCLES);

    lock_state_t         state, state_nxt;
    logic [CNT_W-1:0]    lock_cnt, lock_cnt_nxt;
    logic                run_ok, chan_ok, cfg_ok, accept, err_q;
    logic [CHANNELS-1:0] en_raw, pend;

    // Lock FSM state and qualification counter.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= LOCK_UNLOCKED;
            lock_cnt <= '0;
        end else begin
            state    <= state_nxt;
            lock_cnt <= lock_cnt_nxt;
        end
    end

    // Lock FSM next state: any low lock sample restarts qualification.
    always_comb begin
        state_nxt    = state;
        lock_cnt_nxt = lock_cnt;
        if (!PllLocked) begin
            state_nxt    = LOCK_UNLOCKED;
            lock_cnt_nxt = '0;
        end else begin
            case (state)
                LOCK_UNLOCKED: begin
                    if (lock_cnt == LOCK_LAST) begin
                        state_nxt    = LOCK_RUN;
                        lock_cnt_nxt = LOCK_FULL;
                    end else begin
                        lock_cnt_nxt = lock_cnt + CNT_W'(1);
                    end
                end
                default: state_nxt = LOCK_RUN;
            endcase
        end
    end

    assign Running = (state == LOCK_RUN);
    // A low lock sample already blocks this cycle's advance and clears phases.
    assign run_ok  = Running && PllLocked;

    assign chan_ok = ({{(32-CH_W){1'b0}}, CfgChan} < 32'(CHANNELS));
    assign cfg_ok  = chan_ok && (CfgMod != '0) && (CfgInc <= CfgMod);

    // A channel holding a pending rate refuses further configs.
    always_comb begin
        CfgReady = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
            if (CfgChan == CH_W'(i)) begin
                CfgReady = !pend[i];
            end
        end
    end

    assign accept = CfgValid && CfgReady;

    // Rejection flag for the config accepted in the previous cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= accept && !cfg_ok;
        end
    end

    assign CfgErr = err_q;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        clk_enable_nco #(.ACC_W(ACC_W)) u_nco (
            .clk      (Clk),
            .rst      (Reset),
            .advance  (run_ok && ChanEnable[g]),
            .disabled (!ChanEnable[g]),
            .sync     (Sync),
            .load     (accept && cfg_ok && (CfgChan == CH_W'(g))),
            .load_inc (CfgInc),
            .load_mod (CfgMod),
            .en       (en_raw[g]),
            .pending  (pend[g])
        );
    end

    // Strobes vanish in the very cycle the lock drops.
    assign ClkEn      = en_raw & {CHANNELS{PllLocked}};
    assign CfgPending = pend;

endmodule
